bus_interconnect: RTL and testbench
===================================

// Module: bus_interconnect
// PURPOSE
// - Network-side end of the xctcmsg bus protocol. It arbitrates among N node adapters' send ports
//   (val/dst/tag/msg with ack) and delivers each message to the destination's receive port
//   (val/src/tag/msg with rdy).
// - One-entry registered transfer slot, round-robin grant, full throughput of 1 msg/cycle.
// PARAMETERS
// - N_NODES  default 4   number of attached adapters (2..16)
// - ADDR_W   default 4   width of dst/src node address; requires 2**ADDR_W >= N_NODES
// - TAG_W    default 8   message tag width
// - MSG_W    default 32  message payload width
// PORTS
// - clk         in   1             clock
// - rst_n       in   1             asynchronous, active-low reset
// - node_val_i  in   N_NODES       per-node send request (adapter bus_val_o)
// - node_dst_i  in   N_NODES*ADDR_W  per-node destination, node k at [k*ADDR_W +: ADDR_W]
// - node_tag_i  in   N_NODES*TAG_W   per-node tag, same packing
// - node_msg_i  in   N_NODES*MSG_W   per-node payload, same packing
// - node_ack_o  out  N_NODES       per-node accept pulse (adapter bus_ack_i)
// - node_val_o  out  N_NODES       per-node delivery valid, at most one bit set (adapter bus_val_i)
// - node_src_o  out  ADDR_W        sender address of the delivered msg, shared by all nodes
// - node_tag_o  out  TAG_W         tag of the delivered msg, shared
// - node_msg_o  out  MSG_W         payload of the delivered msg, shared
// - node_rdy_i  in   N_NODES       per-node receive ready (adapter bus_rdy_o)
// - drop_cnt_o  out  16            dropped-message counter (XCTCMSG_BUS_DROP_COUNT_EN only)
// BEHAVIOUR
// - Reset: slot empty, rr_ptr=0, node_ack_o=0, node_val_o=0, src/tag/msg=0, drop_cnt_o=0.
// - Slot states: EMPTY / FULL(src,dst,tag,msg).
//   - deliver = FULL & node_rdy_i[dst].
//   - can_capture = EMPTY | deliver.
// - Arbitration, combinational each cycle:
//   - Scan node_val_i from index rr_ptr upward, wrapping at N_NODES-1 to 0.
//   - First set bit is the grant g. No set bit means no grant.
// - Capture: when can_capture and a grant exists:
//   - node_ack_o[g]=1 for exactly that cycle.
//   - Next cycle the slot holds {src=g, dst, tag, msg} of node g.
//   - rr_ptr <= (g+1) mod N_NODES.
// - No grant or no can_capture: node_ack_o all 0 and rr_ptr unchanged.
// - Ack is combinational from node_val_i and slot state. It is loop-free because adapter val is registered.
// - Delivery: while FULL and dst < N_NODES:
//   - node_val_o = onehot(dst); src/tag/msg come from the slot.
//   - Outputs are held stable until node_rdy_i[dst]=1.
//   - In the deliver cycle the slot goes EMPTY, or refills if a capture happens in the same cycle.
//     A refill gives back-to-back delivery without a bubble.
// - Latency: request seen in cycle t gets ack in t. Delivery valid is in t+1 at the earliest.
// - Self-send (dst==src) is legal and delivered normally.
// - Invalid dst (dst >= N_NODES):
//   - Still acked at capture.
//   - The slot is consumed in the next cycle with node_val_o=0 (treated as deliver=1).
//   - The message is discarded.
// - When EMPTY: node_val_o=0; src/tag/msg hold their last values (don't-care).
// - Reset mid-delivery: the in-flight message is lost. Every output returns to its reset value asynchronously.
// - Adapter-side invariant (checked): node_val_i[k], once high, stays high with stable data until node_ack_o[k].
// CONFIGURATION
// - XCTCMSG_BUS_DROP_COUNT_EN defined:
//   - drop_cnt_o increments by 1 per discarded invalid-dst message, in the discard cycle.
//   - It saturates at 16'hFFFF.
// - Undefined: no counter flops; drop_cnt_o is tied to 0. Discard behaviour is otherwise identical.
// TESTING
// - T1 single send: node1 val, dst=2, tag=8'h03, msg=32'hA5, rdy all 1
//   -> ack[1] pulses in cycle t only.
//   -> In t+1: node_val_o=4'b0100, src=1, tag=3, msg=32'hA5.
//   -> In t+2: node_val_o=0.
// - T2 backpressure: as T1 with rdy[2]=0 for 5 cycles
//   -> node_val_o[2] is held 6 cycles with data stable.
//   -> Node0 requesting meanwhile gets no ack until the deliver cycle, then is acked in that cycle.
// - T3 contention: nodes 0,1,3 valid from reset, each a new msg after ack, rdy all 1
//   -> Grants run 0,1,3,0,1,3 in consecutive cycles and deliveries are back-to-back.
//   -> Node2 never sees node_val_o except for msgs addressed to it.
// - T4 invalid dst: node3 sends dst=7 with N_NODES=4
//   -> ack[3] pulses and node_val_o stays 0.
//   -> With the _EN macro, drop_cnt_o goes 0->1. Without it, drop_cnt_o stays 0.
// - T5 reset mid-op: rst_n low while slot FULL with rdy[dst]=0
//   -> All outputs are 0 immediately.
//   -> After release, rr_ptr=0: node0 wins over node2 when both request.
// - T6 self-send and wrap: rr_ptr=3, nodes 0 and 3 valid, node3 dst=3
//   -> node3 is granted first, then node0.
//   -> node_val_o[3] is seen with src=3.

Source files
------------

// File: rtl/bus_interconnect.sv
// Network-side xctcmsg bus interconnect: round-robin arbiter feeding a one-entry registered transfer slot.
// Define XCTCMSG_BUS_DROP_COUNT_EN to build the saturating invalid-destination drop counter.
module bus_interconnect #(
   parameter int N_NODES = 4,
   parameter int ADDR_W  = 4,
   parameter int TAG_W   = 8,
   parameter int MSG_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_NODES-1:0]         node_val_i,
   input  logic [N_NODES*ADDR_W-1:0]  node_dst_i,
   input  logic [N_NODES*TAG_W-1:0]   node_tag_i,
   input  logic [N_NODES*MSG_W-1:0]   node_msg_i,
   output logic [N_NODES-1:0]         node_ack_o,
   output logic [N_NODES-1:0]         node_val_o,
   output logic [ADDR_W-1:0]          node_src_o,
   output logic [TAG_W-1:0]           node_tag_o,
   output logic [MSG_W-1:0]           node_msg_o,
   input  logic [N_NODES-1:0]         node_rdy_i,
   output logic [15:0]                drop_cnt_o
);

   localparam int PTR_W = $clog2(N_NODES);

   typedef enum logic {EMPTY, FULL} slot_state_e;

   slot_state_e        state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [ADDR_W-1:0]  src_q, dst_q;
   logic [TAG_W-1:0]   tag_q;
   logic [MSG_W-1:0]   msg_q;

   logic               dst_hit, rdy_sel, deliver, can_capture, capture, grant_vld;
   logic [PTR_W-1:0]   grant;
   logic [ADDR_W-1:0]  grant_dst;
   logic [TAG_W-1:0]   grant_tag;
   logic [MSG_W-1:0]   grant_msg;

   // Decode the slot's destination; an out-of-range dst is consumed silently.
   always_comb begin
      dst_hit    = 1'b0;
      rdy_sel    = 1'b0;
      node_val_o = '0;
      for (int k = 0; k < N_NODES; k++) begin
         if (dst_q == ADDR_W'(k)) begin
            dst_hit       = 1'b1;
            rdy_sel       = node_rdy_i[k];
            node_val_o[k] = (state_q == FULL);
         end
      end
   end

   assign deliver     = (state_q == FULL) && (!dst_hit || rdy_sel);
   assign can_capture = (state_q == EMPTY) || deliver;

   // Round-robin scan starting at rr_ptr and wrapping; first requester wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant     = '0;
      grant_dst = '0;
      grant_tag = '0;
      grant_msg = '0;
      for (int i = 0; i < N_NODES; i++) begin
         idx = (int'(rr_ptr_q) + i) % N_NODES;
         if (!grant_vld && node_val_i[idx]) begin
            grant_vld = 1'b1;
            grant     = PTR_W'(idx);
            grant_dst = node_dst_i[idx*ADDR_W +: ADDR_W];
            grant_tag = node_tag_i[idx*TAG_W +: TAG_W];
            grant_msg = node_msg_i[idx*MSG_W +: MSG_W];
         end
      end
   end

   // Ack is gated by rst_n so it drops with the asynchronous reset like every other output.
   always_comb begin
      state_d    = state_q;
      capture    = rst_n && can_capture && grant_vld;
      node_ack_o = '0;
      if (deliver)
         state_d = EMPTY;
      if (capture)
         state_d = FULL;
      for (int k = 0; k < N_NODES; k++)
         node_ack_o[k] = capture && (grant == PTR_W'(k));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         rr_ptr_q <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         tag_q    <= '0;
         msg_q    <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            src_q    <= ADDR_W'(grant);
            dst_q    <= grant_dst;
            tag_q    <= grant_tag;
            msg_q    <= grant_msg;
            rr_ptr_q <= PTR_W'((int'(grant) + 1) % N_NODES);
         end
      end
   end

   assign node_src_o = src_q;
   assign node_tag_o = tag_q;
   assign node_msg_o = msg_q;

`ifdef XCTCMSG_BUS_DROP_COUNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt_q <= '0;
      else if ((state_q == FULL) && !dst_hit && (drop_cnt_q != 16'hFFFF))
         drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign drop_cnt_o = 16'd0;
`endif

   // Adapters must hold val and data stable until acked; these flops only feed the check.
   logic [N_NODES-1:0]        pend_q;
   logic [N_NODES*ADDR_W-1:0] pend_dst_q;
   logic [N_NODES*TAG_W-1:0]  pend_tag_q;
   logic [N_NODES*MSG_W-1:0]  pend_msg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         pend_dst_q <= '0;
         pend_tag_q <= '0;
         pend_msg_q <= '0;
      end else begin
         for (int k = 0; k < N_NODES; k++) begin
            if (pend_q[k])
               assert (node_val_i[k]
                       && node_dst_i[k*ADDR_W +: ADDR_W] == pend_dst_q[k*ADDR_W +: ADDR_W]
                       && node_tag_i[k*TAG_W +: TAG_W]   == pend_tag_q[k*TAG_W +: TAG_W]
                       && node_msg_i[k*MSG_W +: MSG_W]   == pend_msg_q[k*MSG_W +: MSG_W]);
         end
         pend_q     <= node_val_i & ~node_ack_o;
         pend_dst_q <= node_dst_i;
         pend_tag_q <= node_tag_i;
         pend_msg_q <= node_msg_i;
      end
   end

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed scenarios plus randomized traffic against a reference model.
module tb_bus_interconnect;

   localparam int N  = 4;
   localparam int AW = 4;
   localparam int TW = 8;
   localparam int MW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    node_val_i, node_ack_o, node_val_o, node_rdy_i;
   logic [N*AW-1:0] node_dst_i;
   logic [N*TW-1:0] node_tag_i;
   logic [N*MW-1:0] node_msg_i;
   logic [AW-1:0]   node_src_o;
   logic [TW-1:0]   node_tag_o;
   logic [MW-1:0]   node_msg_o;
   logic [15:0]     drop_cnt_o;

   always #5 clk = ~clk;

   bus_interconnect #(.N_NODES(N), .ADDR_W(AW), .TAG_W(TW), .MSG_W(MW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .node_val_i (node_val_i),
      .node_dst_i (node_dst_i),
      .node_tag_i (node_tag_i),
      .node_msg_i (node_msg_i),
      .node_ack_o (node_ack_o),
      .node_val_o (node_val_o),
      .node_src_o (node_src_o),
      .node_tag_o (node_tag_o),
      .node_msg_o (node_msg_o),
      .node_rdy_i (node_rdy_i),
      .drop_cnt_o (drop_cnt_o)
   );

   int vectors = 0;
   int miscompares = 0;

   // Adapter side: pending request per node and receive readiness.
   logic [N-1:0]  a_val = '0;
   logic [N-1:0]  rdy_v = '1;
   logic [AW-1:0] a_dst [N];
   logic [TW-1:0] a_tag [N];
   logic [MW-1:0] a_msg [N];
   bit            refill = 1'b0;
   int            max_dst = 3;

   // Reference model: transfer slot contents, round-robin start, discard count, grant history.
   bit            m_full = 1'b0;
   int            m_src, m_dst, m_rr, m_drops;
   logic [TW-1:0] m_tag;
   logic [MW-1:0] m_msg;
   int            grants[$];

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic newMsg(input int k);
      a_val[k] = 1'b1;
      a_dst[k] = AW'($urandom_range(0, max_dst));
      a_tag[k] = TW'($urandom);
      a_msg[k] = $urandom;
   endtask

   task automatic applyStimulus();
      node_val_i = a_val;
      node_rdy_i = rdy_v;
      for (int k = 0; k < N; k++) begin
         node_dst_i[k*AW +: AW] = a_dst[k];
         node_tag_i[k*TW +: TW] = a_tag[k];
         node_msg_i[k*MW +: MW] = a_msg[k];
      end
   endtask

   // Compare this cycle's outputs with the model, then advance the model across the coming edge.
   task automatic checkOutput();
      bit           dst_ok, deliver, cap;
      int           g, exp_drop;
      logic [N-1:0] exp_ack, exp_val;
      dst_ok  = m_full && (m_dst < N);
      deliver = m_full && (!dst_ok || rdy_v[m_dst]);
      cap     = !m_full || deliver;
      g = -1;
      for (int i = 0; i < N; i++)
         if (g < 0 && a_val[(m_rr + i) % N]) g = (m_rr + i) % N;
      exp_ack = '0;
      if (cap && g >= 0) exp_ack[g] = 1'b1;
      exp_val = '0;
      if (dst_ok) exp_val[m_dst] = 1'b1;
`ifdef XCTCMSG_BUS_DROP_COUNT_EN
      exp_drop = m_drops;
`else
      exp_drop = 0;
`endif
      checkVal("ack", 64'(node_ack_o), 64'(exp_ack));
      checkVal("val", 64'(node_val_o), 64'(exp_val));
      checkVal("drop", 64'(drop_cnt_o), 64'(exp_drop));
      if (dst_ok) begin
         checkVal("src", 64'(node_src_o), 64'(m_src));
         checkVal("tag", 64'(node_tag_o), 64'(m_tag));
         checkVal("msg", 64'(node_msg_o), 64'(m_msg));
      end
      if (m_full && !dst_ok && m_drops < 65535) m_drops++;
      if (deliver) m_full = 1'b0;
      if (cap && g >= 0) begin
         m_full = 1'b1;
         m_src  = g;
         m_dst  = int'(a_dst[g]);
         m_tag  = a_tag[g];
         m_msg  = a_msg[g];
         m_rr   = (g + 1) % N;
         grants.push_back(g);
         if (refill) newMsg(g);
         else        a_val[g] = 1'b0;
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1 applyStimulus();
      @(negedge clk);
      checkOutput();
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
   task automatic resetDut();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkVal("rst_ack", 64'(node_ack_o), 64'h0);
      checkVal("rst_val", 64'(node_val_o), 64'h0);
      checkVal("rst_src", 64'(node_src_o), 64'h0);
      checkVal("rst_tag", 64'(node_tag_o), 64'h0);
      checkVal("rst_msg", 64'(node_msg_o), 64'h0);
      checkVal("rst_drop", 64'(drop_cnt_o), 64'h0);
      m_full  = 1'b0;
      m_rr    = 0;
      m_drops = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus();
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      int exp_g[6];
      for (int k = 0; k < N; k++) begin
         a_dst[k] = '0;
         a_tag[k] = '0;
         a_msg[k] = '0;
      end
      applyStimulus();
      resetDut();

      // T1 single send
      stepCycle();
      a_val[1] = 1'b1; a_dst[1] = 4'd2; a_tag[1] = 8'h03; a_msg[1] = 32'hA5;
      stepCycle();
      checkVal("t1_ack", 64'(node_ack_o), 64'h2);
      stepCycle();
      checkVal("t1_val", 64'(node_val_o), 64'h4);
      checkVal("t1_src", 64'(node_src_o), 64'h1);
      checkVal("t1_tag", 64'(node_tag_o), 64'h3);
      checkVal("t1_msg", 64'(node_msg_o), 64'hA5);
      checkVal("t1_ack_gone", 64'(node_ack_o), 64'h0);
      stepCycle();
      checkVal("t1_idle", 64'(node_val_o), 64'h0);

      // T2 backpressure
      a_val[1] = 1'b1; a_dst[1] = 4'd2; a_tag[1] = 8'h11; a_msg[1] = 32'h1234_5678;
      stepCycle();
      checkVal("t2_ack1", 64'(node_ack_o), 64'h2);
      rdy_v[2] = 1'b0;
      a_val[0] = 1'b1; a_dst[0] = 4'd1; a_tag[0] = 8'h22; a_msg[0] = 32'hCAFE;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkVal("t2_hold_val", 64'(node_val_o), 64'h4);
         checkVal("t2_hold_msg", 64'(node_msg_o), 64'h1234_5678);
         checkVal("t2_no_ack", 64'(node_ack_o), 64'h0);
      end
      rdy_v[2] = 1'b1;
      stepCycle();
      checkVal("t2_last_val", 64'(node_val_o), 64'h4);
      checkVal("t2_ack0", 64'(node_ack_o), 64'h1);
      stepCycle();
      checkVal("t2_next_val", 64'(node_val_o), 64'h2);
      checkVal("t2_next_src", 64'(node_src_o), 64'h0);
      stepCycle();

      // T3 contention from reset
      refill = 1'b1;
      newMsg(0); newMsg(1); newMsg(3);
      grants.delete();
      resetDut();
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkVal("t3_b2b", 64'(|node_val_o), 64'h1);
      end
      exp_g = '{0, 1, 3, 0, 1, 3};
      checkVal("t3_ngrants", 64'(grants.size()), 64'h6);
      for (int i = 0; i < 6 && i < grants.size(); i++)
         checkVal("t3_order", 64'(grants[i]), 64'(exp_g[i]));
      refill = 1'b0;
      for (int i = 0; i < 5; i++) stepCycle();

      // T4 invalid destination
      a_val[3] = 1'b1; a_dst[3] = 4'd7; a_tag[3] = 8'h44; a_msg[3] = 32'hDEAD;
      stepCycle();
      checkVal("t4_ack", 64'(node_ack_o), 64'h8);
      stepCycle();
      checkVal("t4_val", 64'(node_val_o), 64'h0);
      checkVal("t4_drop_pre", 64'(drop_cnt_o), 64'h0);
      stepCycle();
`ifdef XCTCMSG_BUS_DROP_COUNT_EN
      checkVal("t4_drop_post", 64'(drop_cnt_o), 64'h1);
`else
      checkVal("t4_drop_post", 64'(drop_cnt_o), 64'h0);
`endif

      // T5 reset while the slot is stalled
      rdy_v[2] = 1'b0;
      a_val[1] = 1'b1; a_dst[1] = 4'd2; a_tag[1] = 8'h55; a_msg[1] = 32'h5555;
      stepCycle();
      checkVal("t5_ack1", 64'(node_ack_o), 64'h2);
      a_val[0] = 1'b1; a_dst[0] = 4'd1; a_tag[0] = 8'h66; a_msg[0] = 32'h6666;
      a_val[2] = 1'b1; a_dst[2] = 4'd3; a_tag[2] = 8'h77; a_msg[2] = 32'h7777;
      stepCycle();
      checkVal("t5_stall_val", 64'(node_val_o), 64'h4);
      resetDut();
      checkVal("t5_grant0", 64'(node_ack_o), 64'h1);
      rdy_v[2] = 1'b1;
      stepCycle();
      checkVal("t5_grant2", 64'(node_ack_o), 64'h4);
      stepCycle();

      // T6 pointer wrap and self-send
      a_val[0] = 1'b1; a_dst[0] = 4'd1; a_tag[0] = 8'h88; a_msg[0] = 32'h8888;
      a_val[3] = 1'b1; a_dst[3] = 4'd3; a_tag[3] = 8'h99; a_msg[3] = 32'h9999;
      stepCycle();
      checkVal("t6_ack3", 64'(node_ack_o), 64'h8);
      stepCycle();
      checkVal("t6_ack0", 64'(node_ack_o), 64'h1);
      checkVal("t6_self_val", 64'(node_val_o), 64'h8);
      checkVal("t6_self_src", 64'(node_src_o), 64'h3);
      stepCycle();

      // Randomized traffic including out-of-range destinations
      max_dst = 5;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!a_val[k] && $urandom_range(0, 2) == 0) newMsg(k);
            rdy_v[k] = ($urandom_range(0, 3) != 0);
         end
         stepCycle();
      end
      rdy_v = '1;
      for (int i = 0; i < 8; i++) stepCycle();
      checkVal("drain_empty", 64'(a_val), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
